// File: rtl/vga_pkg.sv
// Shared video timing types and default 640x480@60 constants.
package vga_pkg;

  typedef logic [9:0] pos_t;

  localparam int unsigned POS_LIMIT = 1024;
  localparam int unsigned PIX_DIV   = 4;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // True when p lies in [lo, lo+len).
  function automatic logic in_window(pos_t p, int unsigned lo, int unsigned len);
    return (32'(p) >= lo) && (32'(p) < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen_clk_en_div.sv
// Divide-by-N enable generator: registered one-clk pulse every N clk.
module clk_en_div #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic reset,
  output logic en
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d;

  // Free-running prescaler; enable fires in the clk after the terminal count.
  always_comb begin
    cnt_d = (cnt_q == CW'(N - 1)) ? '0 : cnt_q + CW'(1);
    en_d  = (cnt_q == CW'(N - 1));
  end

  // Prescaler state, asynchronously cleared so the phase restarts on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end

  assign en = en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing source: pixel enable, position counters, blank and syncs.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic       clk25en,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       blank,
  output logic       h_sync,
  output logic       v_sync,
  output logic       vblank_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((H_TOTAL > POS_LIMIT) || (V_TOTAL > POS_LIMIT)) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic pix_en;

  clk_en_div #(.N(PIX_DIV)) u_pix_div (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en)
  );

  pos_t x_q, x_d, y_q, y_d;
  logic blank_q, blank_d;
  logic h_sync_q, h_sync_d;
  logic v_sync_q, v_sync_d;
  logic vbs_q, vbs_d;

  // Next position plus decodes taken from the next position, so every
  // registered output lines up with the counters in the same edge.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_en) begin
      if (x_q == pos_t'(H_TOTAL - 1)) begin
        x_d = '0;
        y_d = (y_q == pos_t'(V_TOTAL - 1)) ? '0 : y_q + pos_t'(1);
      end else begin
        x_d = x_q + pos_t'(1);
      end
    end
    blank_d  = (32'(x_d) >= H_ACTIVE) || (32'(y_d) >= V_ACTIVE);
    h_sync_d = !in_window(x_d, H_ACTIVE + H_FP, H_SYNC);
    v_sync_d = !in_window(y_d, V_ACTIVE + V_FP, V_SYNC);
    vbs_d    = pix_en && (x_d == '0) && (y_d == pos_t'(V_ACTIVE));
  end

  // Position and timing flags, asynchronously returned to pixel (0,0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q      <= '0;
      y_q      <= '0;
      blank_q  <= 1'b0;
      h_sync_q <= 1'b1;
      v_sync_q <= 1'b1;
      vbs_q    <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      blank_q  <= blank_d;
      h_sync_q <= h_sync_d;
      v_sync_q <= v_sync_d;
      vbs_q    <= vbs_d;
    end
  end

  assign clk25en      = pix_en;
  assign x_pos        = x_q;
  assign y_pos        = y_q;
  assign blank        = blank_q;
  assign h_sync       = h_sync_q;
  assign v_sync       = v_sync_q;
  assign vblank_start = vbs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen with a shortened frame (8 lines).
module tb_vga_timing_gen;

  // Vertical timing shrunk to keep two full frames short:
  // V_ACTIVE=4, v_sync low on lines 5..6, V_TOTAL=8, frame = 25600 clk.
  localparam int unsigned H_TOT      = 800;
  localparam int unsigned V_TOT      = 8;
  localparam int unsigned V_ACT      = 4;
  localparam int unsigned FRAME_CLK  = 25600;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk25en, blank, h_sync, v_sync, vblank_start;
  logic [9:0] x_pos, y_pos;

  int checks = 0;
  int failures = 0;

  localparam logic [24:0] RESET_VEC = {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};

  vga_timing_gen #(
    .H_ACTIVE (640), .H_FP (16), .H_SYNC (96), .H_BP (48),
    .V_ACTIVE (4),   .V_FP (1),  .V_SYNC (2),  .V_BP (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk25en      (clk25en),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .blank        (blank),
    .h_sync       (h_sync),
    .v_sync       (v_sync),
    .vblank_start (vblank_start)
  );

  always #5 clk = ~clk;

  logic [24:0] dut_vec;
  assign dut_vec = {clk25en, x_pos, y_pos, blank, h_sync, v_sync, vblank_start};

  // Closed-form expectation k clk edges after reset release.
  function automatic logic [24:0] model_vec(int unsigned k);
    int unsigned p, x, y;
    logic en, bl, hs, vs, vb;
    p  = (k >= 1) ? (k - 1) / 4 : 0;
    x  = p % H_TOT;
    y  = (p / H_TOT) % V_TOT;
    en = (k >= 4) && (k % 4 == 0);
    bl = (x >= 640) || (y >= V_ACT);
    hs = !((x >= 656) && (x < 752));
    vs = !((y >= 5) && (y < 7));
    vb = (k >= 5) && ((k - 1) % 4 == 0) && (x == 0) && (y == V_ACT);
    return {en, 10'(x), 10'(y), bl, hs, vs, vb};
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    int highs = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h", dut_vec, RESET_VEC);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int unsigned k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (clk25en) highs++;
      checks++;
      if (clk25en !== (k % 4 == 0)) begin
        failures++;
        $display("FAIL clk25en_phase k=%0d got=%b exp=%b", k, clk25en, (k % 4 == 0));
      end
    end
    checks++;
    if (highs != 4) begin
      failures++;
      $display("FAIL clk25en_duty got=%0d exp=4", highs);
    end
  endtask

  task automatic test_hsync_window();
    int low_cnt = 0, blank_cnt = 0;
    int unsigned first_x = 0, last_x = 0;
    apply_reset();
    for (int unsigned k = 1; k <= 3200; k++) begin
      @(posedge clk);
      #1;
      if (y_pos == 10'd0) begin
        if (!h_sync) begin
          if (low_cnt == 0) first_x = 32'(x_pos);
          last_x = 32'(x_pos);
          low_cnt++;
        end
        if (blank) blank_cnt++;
      end
    end
    checks++;
    if (first_x != 656) begin failures++; $display("FAIL hsync_first_x got=%0d exp=656", first_x); end
    checks++;
    if (last_x != 751) begin failures++; $display("FAIL hsync_last_x got=%0d exp=751", last_x); end
    checks++;
    if (low_cnt != 384) begin failures++; $display("FAIL hsync_low_clk got=%0d exp=384", low_cnt); end
    checks++;
    if (blank_cnt != 640) begin failures++; $display("FAIL hblank_clk got=%0d exp=640", blank_cnt); end
  endtask

  task automatic test_line_wrap();
    int unsigned k799 = 0, k_y1 = 0, k_y2 = 0;
    apply_reset();
    for (int unsigned k = 1; k <= 6401; k++) begin
      @(posedge clk);
      #1;
      if (k799 == 0 && x_pos == 10'd799 && y_pos == 10'd0) k799 = k;
      if (k_y1 == 0 && y_pos == 10'd1) k_y1 = k;
      if (k_y2 == 0 && y_pos == 10'd2) k_y2 = k;
      if (k == 3201) begin
        checks++;
        if ({x_pos, y_pos, blank} !== {10'd0, 10'd1, 1'b0}) begin
          failures++;
          $display("FAIL line_wrap got x=%0d y=%0d blank=%b exp x=0 y=1 blank=0", x_pos, y_pos, blank);
        end
      end
    end
    checks++;
    if (k799 != 3197) begin failures++; $display("FAIL x799_edge got=%0d exp=3197", k799); end
    checks++;
    if (k_y2 - k_y1 != 3200) begin
      failures++;
      $display("FAIL line_period got=%0d exp=3200", k_y2 - k_y1);
    end
  endtask

  task automatic test_frame_scoreboard();
    int sb_fail = 0, pulses = 0, vs_cnt = 0;
    int unsigned first_pulse = 0;
    logic [24:0] exp_v;
    apply_reset();
    for (int unsigned k = 1; k <= 2 * FRAME_CLK + 8; k++) begin
      @(posedge clk);
      #1;
      exp_v = model_vec(k);
      checks++;
      if (dut_vec !== exp_v) begin
        failures++;
        sb_fail++;
        $display("FAIL scoreboard k=%0d got=%h exp=%h", k, dut_vec, exp_v);
        if (sb_fail >= 10) break;
      end
      if (vblank_start) begin
        pulses++;
        if (first_pulse == 0) first_pulse = k;
      end
      if (k <= FRAME_CLK && !v_sync) vs_cnt++;
      if (k == FRAME_CLK + 1) begin
        checks++;
        if ({x_pos, y_pos} !== {10'd0, 10'd0}) begin
          failures++;
          $display("FAIL frame_wrap got x=%0d y=%0d exp x=0 y=0", x_pos, y_pos);
        end
      end
    end
    checks++;
    if (pulses != 2) begin failures++; $display("FAIL vblank_pulses got=%0d exp=2", pulses); end
    checks++;
    if (first_pulse != 12801) begin
      failures++;
      $display("FAIL vblank_first_edge got=%0d exp=12801", first_pulse);
    end
    checks++;
    if (vs_cnt != 6400) begin failures++; $display("FAIL vsync_low_clk got=%0d exp=6400", vs_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    logic [24:0] exp_v;
    apply_reset();
    for (int unsigned k = 1; k <= 7602; k++) @(posedge clk);
    #1;
    checks++;
    if ({x_pos, y_pos} !== {10'd300, 10'd2}) begin
      failures++;
      $display("FAIL midframe_pos got x=%0d y=%0d exp x=300 y=2", x_pos, y_pos);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dut_vec !== RESET_VEC) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", dut_vec, RESET_VEC);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int unsigned k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      exp_v = model_vec(k);
      checks++;
      if (dut_vec !== exp_v) begin
        failures++;
        $display("FAIL restart k=%0d got=%h exp=%h", k, dut_vec, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hsync_window();
    test_line_wrap();
    test_frame_scoreboard();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
